filter_rx_arb: RTL and testbench
================================

Name: filter_rx_arb

Overview:
- 2:1 packet-atomic weighted round-robin arbiter in box_250mhz.
- Merges two 512-bit AXI-Stream RX sources (e.g. adapter RX and a loopback/injection path) into the single slave input of the filter RX pipeline.
- A grant is held from the first beat of a packet until its tlast beat is accepted, so packets never interleave downstream.
- One registered output stage; per-source packet counters are exported for status.

Parameters:
- WEIGHT0, 1: consecutive packets source 0 may send per turn while source 1 is waiting (1..15).
- WEIGHT1, 1: same for source 1.
- CNT_W, 32: width of the per-source packet counters.

Ports:
- aclk  in  1  clock (250 MHz domain)
- areset  in  1  asynchronous, active-high reset
- s0_axis_tvalid/tdata/tkeep/tlast/tuser  in  1/512/64/1/48  source 0 stream
- s0_axis_tready  out  1  source 0 ready
- s1_axis_tvalid/tdata/tkeep/tlast/tuser  in  1/512/64/1/48  source 1 stream
- s1_axis_tready  out  1  source 1 ready
- m_axis_tvalid/tdata/tkeep/tlast/tuser  out  1/512/64/1/48  to filter RX pipeline
- m_axis_tready  in  1  downstream ready
- pkt_cnt0  out  CNT_W  packets accepted from source 0 (tlast beats)
- pkt_cnt1  out  CNT_W  packets accepted from source 1
- busy  out  1  high in LOCK0/LOCK1

Behaviour:
- Reset (async assert, sync to aclk on release):
  - m_axis_tvalid=0, all s*_tready=0, pkt_cnt*=0, busy=0.
  - state=IDLE, pref=0, credit=WEIGHT0.
  - m_axis_tdata/tkeep/tlast/tuser are don't-care while tvalid=0.
- Output stage: stage_ready = !m_axis_tvalid || m_axis_tready. Accepted beat appears on m_axis the next cycle (1-cycle latency). tdata/tkeep/tlast/tuser are passed through unmodified.
- FSM states: IDLE, LOCK0, LOCK1.
- IDLE winner selection (combinational):
  - Only one source valid -> that source wins.
  - Both valid -> pref wins.
  - Winner's tready = stage_ready; the other source's tready = 0.
- IDLE transitions, on winner beat accepted:
  - tlast=1 -> stay IDLE (single-beat packet).
  - tlast=0 -> LOCKn.
- LOCKn:
  - s{n}_tready = stage_ready; the other tready = 0.
  - Leave to IDLE on the accepted beat with tlast=1.
  - tvalid gaps mid-packet hold the lock indefinitely; no timeout.
- Packet completion (tlast accepted from source n):
  - pkt_cntn increments and wraps at 2^CNT_W-1 -> 0.
  - Credit update when n==pref:
    - credit decrements.
    - If credit reaches 0, or the other source's tvalid is high and credit was 1: pref flips and credit reloads with the new pref's weight.
  - Credit update when n!=pref (won because pref was idle): pref flips to the other source (giving the idle source the next turn); credit reloads.
- Arbitration is decided only in IDLE, never mid-packet. A source dropping tvalid in IDLE before acceptance is legal; selection re-evaluates each cycle.
- Back-to-back packets: a new packet may be accepted in the cycle immediately after a tlast accept (IDLE is re-entered with no bubble).
- m_axis_tready=0: output holds stable, all s*_tready=0, state frozen.
- Async reset mid-packet: output is invalidated immediately; the partial packet is discarded. Sources must restart at a packet boundary.

Optional Feature:
- FILTER_RX_ARB_SRC_TAG_EN
  - Defined: m_axis_tuser[47] is overwritten with the granting source index (0/1); other tuser bits pass through.
  - Undefined: tuser passes through unchanged.

Decomposition:
- Shared package: arb_state_e enum (IDLE/LOCK0/LOCK1), ARB_SRC_TAG_BIT = 47, arb_status_t struct {pkt_cnt0, pkt_cnt1, busy} for later aggregation into status_reg_t.
- One sub-module, axis_reg_slice: the 1-deep registered output stage (valid/ready, 625-bit payload). The arbiter FSM and credits stay in the top.

Test Plan:
- Single source: s0 sends 3-beat packet, s1 idle, m_axis_tready=1 -> 3 beats on m_axis starting 1 cycle after first accept; pkt_cnt0=1, pkt_cnt1=0.
- Contention, WEIGHT0=WEIGHT1=1: both sources continuously offer 2-beat packets -> output packet order 0,1,0,1; no interleaving; no idle cycles between packets.
- Weights: WEIGHT0=3, WEIGHT1=1, both saturated for 8 packets -> order 0,0,0,1,0,0,0,1; pkt_cnt0=6, pkt_cnt1=2.
- Backpressure mid-packet: s1 locked on 4-beat packet, m_axis_tready toggled 1,0,0,1...; s0 valid throughout -> s0_tready stays 0 until s1 tlast accepted; beats intact and in order.
- Counter wrap with CNT_W=4: 17 single-beat packets from s0 -> pkt_cnt0=1. Reset asserted mid-packet -> m_axis_tvalid=0 the same cycle; after release, state IDLE and counters 0.
- FILTER_RX_ARB_SRC_TAG_EN defined, s1 sends tuser=48'h0000_0000_0001 -> m_axis_tuser=48'h8000_0000_0001. Undefined -> 48'h0000_0000_0001.

Source files
------------

// File: rtl/filter_rx_arb_pkg.sv
// Shared types for the 2:1 packet-atomic RX arbiter: FSM states, beat payload, status.
package filter_rx_arb_pkg;

  localparam int ARB_DATA_W      = 512;
  localparam int ARB_KEEP_W      = 64;
  localparam int ARB_USER_W      = 48;
  localparam int ARB_SRC_TAG_BIT = 47;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [ARB_DATA_W-1:0] tdata;
    logic [ARB_KEEP_W-1:0] tkeep;
    logic                  tlast;
    logic [ARB_USER_W-1:0] tuser;
  } arb_beat_t;

  // Later folded into the block-level status_reg_t.
  typedef struct packed {
    logic [31:0] pkt_cnt0;
    logic [31:0] pkt_cnt1;
    logic        busy;
  } arb_status_t;

endpackage

// File: rtl/filter_rx_arb_axis_reg_slice.sv
// One-deep registered valid/ready stage; 1-cycle latency, accepts a new beat
// whenever empty or when the current beat is taken in the same cycle.
module axis_reg_slice #(
  parameter int W = 625
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_vld_i,
  input  logic [W-1:0] in_dat_i,
  output logic         in_rdy_o,
  output logic         out_vld_o,
  output logic [W-1:0] out_dat_o,
  input  logic         out_rdy_i
);

  logic         vld_q;
  logic [W-1:0] dat_q;

  assign in_rdy_o  = !vld_q || out_rdy_i;
  assign out_vld_o = vld_q;
  assign out_dat_o = dat_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= 1'b0;
    end else if (in_rdy_o) begin
      vld_q <= in_vld_i;
    end
  end

  // Payload is don't-care while invalid, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (in_rdy_o && in_vld_i) begin
      dat_q <= in_dat_i;
    end
  end

endmodule

// File: rtl/filter_rx_arb.sv
// 2:1 packet-atomic weighted round-robin AXI-Stream arbiter with one registered output stage.
// Optional FILTER_RX_ARB_SRC_TAG_EN: tuser[47] carries the granting source index.
module filter_rx_arb
  import filter_rx_arb_pkg::*;
#(
  parameter int WEIGHT0 = 1,
  parameter int WEIGHT1 = 1,
  parameter int CNT_W   = 32
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             s0_axis_tvalid,
  input  logic [511:0]     s0_axis_tdata,
  input  logic [63:0]      s0_axis_tkeep,
  input  logic             s0_axis_tlast,
  input  logic [47:0]      s0_axis_tuser,
  output logic             s0_axis_tready,
  input  logic             s1_axis_tvalid,
  input  logic [511:0]     s1_axis_tdata,
  input  logic [63:0]      s1_axis_tkeep,
  input  logic             s1_axis_tlast,
  input  logic [47:0]      s1_axis_tuser,
  output logic             s1_axis_tready,
  output logic             m_axis_tvalid,
  output logic [511:0]     m_axis_tdata,
  output logic [63:0]      m_axis_tkeep,
  output logic             m_axis_tlast,
  output logic [47:0]      m_axis_tuser,
  input  logic             m_axis_tready,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1,
  output logic             busy
);

  localparam logic [3:0] W0 = 4'(WEIGHT0);
  localparam logic [3:0] W1 = 4'(WEIGHT1);

  arb_state_e       state_q, state_d;
  logic             pref_q, pref_d;
  logic [3:0]       credit_q, credit_d, credit_dec;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  logic      slice_rdy, stage_rdy;
  logic      sel, sel_vld, sel_last, other_vld, grant_en, acc;
  arb_beat_t beat_in, beat_out;

  // Readies stay low for the whole time reset is held, not just after the flops clear.
  assign stage_rdy = slice_rdy && !areset;

  always_comb begin
    sel        = 1'b0;
    sel_vld    = 1'b0;
    state_d    = state_q;
    pref_d     = pref_q;
    credit_d   = credit_q;
    credit_dec = credit_q - 4'd1;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;

    case (state_q)
      LOCK0: begin
        sel     = 1'b0;
        sel_vld = s0_axis_tvalid;
      end
      LOCK1: begin
        sel     = 1'b1;
        sel_vld = s1_axis_tvalid;
      end
      default: begin
        sel     = (s0_axis_tvalid && s1_axis_tvalid) ? pref_q : s1_axis_tvalid;
        sel_vld = s0_axis_tvalid || s1_axis_tvalid;
      end
    endcase

    grant_en       = (state_q != IDLE) || sel_vld;
    s0_axis_tready = grant_en && !sel && stage_rdy;
    s1_axis_tready = grant_en && sel && stage_rdy;
    sel_last       = sel ? s1_axis_tlast : s0_axis_tlast;
    other_vld      = sel ? s0_axis_tvalid : s1_axis_tvalid;
    acc            = sel_vld && stage_rdy;

    if (acc) begin
      if (!sel_last) begin
        state_d = sel ? LOCK1 : LOCK0;
      end else begin
        state_d = IDLE;
        if (sel) cnt1_d = cnt1_q + 1'b1;
        else     cnt0_d = cnt0_q + 1'b1;
        if (sel == pref_q) begin
          credit_d = credit_dec;
          if (credit_dec == 4'd0 || (other_vld && credit_q == 4'd1)) begin
            pref_d   = !pref_q;
            credit_d = pref_q ? W0 : W1;
          end
        end else begin
          // Won only because the preferred source was idle: hand it the next turn.
          pref_d   = !sel;
          credit_d = sel ? W0 : W1;
        end
      end
    end
  end

  always_comb begin
    beat_in.tdata = sel ? s1_axis_tdata : s0_axis_tdata;
    beat_in.tkeep = sel ? s1_axis_tkeep : s0_axis_tkeep;
    beat_in.tlast = sel_last;
    beat_in.tuser = sel ? s1_axis_tuser : s0_axis_tuser;
`ifdef FILTER_RX_ARB_SRC_TAG_EN
    beat_in.tuser[ARB_SRC_TAG_BIT] = sel;
`endif
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= IDLE;
      pref_q   <= 1'b0;
      credit_q <= W0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      state_q  <= state_d;
      pref_q   <= pref_d;
      credit_q <= credit_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
    end
  end

  axis_reg_slice #(
    .W($bits(arb_beat_t))
  ) u_out_slice (
    .clk_i     (aclk),
    .rst_i     (areset),
    .in_vld_i  (acc),
    .in_dat_i  (beat_in),
    .in_rdy_o  (slice_rdy),
    .out_vld_o (m_axis_tvalid),
    .out_dat_o (beat_out),
    .out_rdy_i (m_axis_tready)
  );

  assign m_axis_tdata = beat_out.tdata;
  assign m_axis_tkeep = beat_out.tkeep;
  assign m_axis_tlast = beat_out.tlast;
  assign m_axis_tuser = beat_out.tuser;
  assign pkt_cnt0     = cnt0_q;
  assign pkt_cnt1     = cnt1_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_filter_rx_arb.sv
// Scoreboard bench for filter_rx_arb (WEIGHT0=3, WEIGHT1=1, CNT_W=4).
module tb_filter_rx_arb;

  localparam int CW = 4;
`ifdef FILTER_RX_ARB_SRC_TAG_EN
  localparam logic [47:0] TAG_EXP = 48'h8000_0000_0001;
`else
  localparam logic [47:0] TAG_EXP = 48'h0000_0000_0001;
`endif

  logic aclk, areset;
  logic s0_axis_tvalid, s0_axis_tlast, s0_axis_tready;
  logic s1_axis_tvalid, s1_axis_tlast, s1_axis_tready;
  logic [511:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
  logic [63:0] s0_axis_tkeep, s1_axis_tkeep, m_axis_tkeep;
  logic [47:0] s0_axis_tuser, s1_axis_tuser, m_axis_tuser;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tready, busy;
  logic [CW-1:0] pkt_cnt0, pkt_cnt1;

  filter_rx_arb #(.WEIGHT0(3), .WEIGHT1(1), .CNT_W(CW)) dut (
    .aclk(aclk), .areset(areset),
    .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep),
    .s0_axis_tlast(s0_axis_tlast), .s0_axis_tuser(s0_axis_tuser), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep),
    .s1_axis_tlast(s1_axis_tlast), .s1_axis_tuser(s1_axis_tuser), .s1_axis_tready(s1_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .busy(busy)
  );

  typedef struct {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
    logic [47:0]  u;
  } exp_t;

  exp_t sbq0[$];
  exp_t sbq1[$];
  int   ord[$];

  int total = 0, bad = 0, cyc = 0;
  int first_in = -1, first_out = -1, last_out = -1, out_beats = 0;
  int s0_rdy_bad = 0, cur_src = 0;
  logic new_pkt = 1'b1, hold_pend = 1'b0, s1_in_pkt = 1'b0, mon_off = 1'b0, bp_mode = 1'b0;
  logic [511:0] hold_d;
  logic [47:0] last_user;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] exp_user(input int src, input logic [47:0] u);
    logic [47:0] r;
    r = u;
`ifdef FILTER_RX_ARB_SRC_TAG_EN
    r[47] = src[0];
`endif
    return r;
  endfunction

  function automatic exp_t mk_beat(input int src, input int pkt, input int beat, input int nb,
                                   input logic [47:0] ub);
    exp_t e;
    e.d = '0;
    e.d[31:0] = {src[7:0], pkt[15:0], beat[7:0]};
    e.d[511:480] = 32'hC0DE_0000 ^ 32'(pkt * 3 + beat);
    e.k = ~64'(beat + pkt);
    e.l = (beat == nb - 1);
    e.u = ub ^ 48'(beat);
    return e;
  endfunction

  // Backpressure pattern 1,0,0,1 repeating when bp_mode is set.
  initial begin
    logic [3:0] pat;
    int k;
    pat = 4'b1001;
    k = 0;
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      if (bp_mode) begin
        m_axis_tready = pat[k];
        k = (k + 1) % 4;
      end else begin
        m_axis_tready = 1'b1;
      end
    end
  end

  task automatic drive(input int src, input int pbase, input int npkt, input int nb, input logic [47:0] ub);
    exp_t e;
    logic hs;
    for (int p = 0; p < npkt; p++) begin
      for (int b = 0; b < nb; b++) begin
        e = mk_beat(src, pbase + p, b, nb, ub);
        if (src == 0) begin
          s0_axis_tvalid = 1'b1; s0_axis_tdata = e.d; s0_axis_tkeep = e.k;
          s0_axis_tlast = e.l; s0_axis_tuser = e.u;
        end else begin
          s1_axis_tvalid = 1'b1; s1_axis_tdata = e.d; s1_axis_tkeep = e.k;
          s1_axis_tlast = e.l; s1_axis_tuser = e.u;
        end
        e.u = exp_user(src, e.u);
        if (src == 0) sbq0.push_back(e);
        else          sbq1.push_back(e);
        hs = 1'b0;
        for (int t = 0; t < 400 && !hs; t++) begin
          @(negedge aclk);
          hs = (src == 0) ? (s0_axis_tvalid && s0_axis_tready) : (s1_axis_tvalid && s1_axis_tready);
          @(posedge aclk);
          #1;
        end
        if (!hs) begin
          check("hs_timeout", 512'(hs), 512'(1));
          return;
        end
      end
    end
    if (src == 0) s0_axis_tvalid = 1'b0;
    else          s1_axis_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 500 && (sbq0.size() + sbq1.size()) != 0; t++) @(negedge aclk);
    @(negedge aclk);
    check("drain", 512'(sbq0.size() + sbq1.size()), 512'(0));
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    s0_axis_tvalid = 1'b1; s1_axis_tvalid = 1'b1;
    s0_axis_tlast = 1'b1;  s1_axis_tlast = 1'b1;
    @(posedge aclk);
    #1;
    check("rst_mvld", 512'(m_axis_tvalid), 512'(0));
    check("rst_s0rdy", 512'(s0_axis_tready), 512'(0));
    check("rst_s1rdy", 512'(s1_axis_tready), 512'(0));
    check("rst_cnt0", 512'(pkt_cnt0), 512'(0));
    check("rst_cnt1", 512'(pkt_cnt1), 512'(0));
    check("rst_busy", 512'(busy), 512'(0));
    s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;
    ord.delete(); sbq0.delete(); sbq1.delete();
    first_in = -1; first_out = -1; last_out = -1; out_beats = 0;
    s0_rdy_bad = 0; new_pkt = 1'b1; hold_pend = 1'b0; s1_in_pkt = 1'b0;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    mon_off = 1'b0;
    @(posedge aclk);
    #1;
  endtask

  always @(negedge aclk) begin
    if (!areset && !mon_off) begin
      exp_t e;
      int exp_src;
      if (hold_pend) begin
        check("hold_vld", 512'(m_axis_tvalid), 512'(1));
        check("hold_dat", m_axis_tdata, hold_d);
      end
      hold_pend = m_axis_tvalid && !m_axis_tready;
      hold_d = m_axis_tdata;
      if (s1_in_pkt && s0_axis_tready) s0_rdy_bad++;
      if (s1_axis_tvalid && s1_axis_tready) s1_in_pkt = !s1_axis_tlast;
      if (first_in < 0 && ((s0_axis_tvalid && s0_axis_tready) || (s1_axis_tvalid && s1_axis_tready)))
        first_in = cyc;
      if (m_axis_tvalid && m_axis_tready) begin
        if (new_pkt) begin
          exp_src = (ord.size() > 0) ? ord.pop_front() : 2;
          check("order_src", 512'(m_axis_tdata[31:24]), 512'(exp_src));
          cur_src = exp_src;
        end
        if (cur_src == 0 && sbq0.size() > 0)      e = sbq0.pop_front();
        else if (cur_src == 1 && sbq1.size() > 0) e = sbq1.pop_front();
        else e = '{d: '1, k: '1, l: 1'b0, u: '1};
        check("beat_data", m_axis_tdata, e.d);
        check("beat_keep", 512'(m_axis_tkeep), 512'(e.k));
        check("beat_last", 512'(m_axis_tlast), 512'(e.l));
        check("beat_user", 512'(m_axis_tuser), 512'(e.u));
        new_pkt = m_axis_tlast;
        last_user = m_axis_tuser;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        out_beats++;
      end
    end
  end

  initial begin
    areset = 1'b0;
    s0_axis_tvalid = 1'b0; s0_axis_tdata = '0; s0_axis_tkeep = '0; s0_axis_tlast = 1'b0; s0_axis_tuser = '0;
    s1_axis_tvalid = 1'b0; s1_axis_tdata = '0; s1_axis_tkeep = '0; s1_axis_tlast = 1'b0; s1_axis_tuser = '0;
    do_reset();

    // Single source, 3-beat packet
    ord.push_back(0);
    drive(0, 1, 1, 3, 48'h8000_0000_0100);
    wait_drain();
    check("single_cnt0", 512'(pkt_cnt0), 512'(1));
    check("single_cnt1", 512'(pkt_cnt1), 512'(0));
    check("single_lat", 512'(first_out - first_in), 512'(1));
    check("single_beats", 512'(out_beats), 512'(3));

    // Weighted contention 3:1, both saturated with 2-beat packets
    do_reset();
    foreach (ord[i]) ord[i] = 0;
    for (int i = 0; i < 8; i++) ord.push_back((i % 4 == 3) ? 1 : 0);
    fork
      drive(0, 10, 6, 2, 48'h8000_0000_1200);
      drive(1, 20, 2, 2, 48'h0000_0000_3400);
    join
    wait_drain();
    check("wrr_cnt0", 512'(pkt_cnt0), 512'(6));
    check("wrr_cnt1", 512'(pkt_cnt1), 512'(2));
    check("wrr_nogap", 512'(last_out - first_out), 512'(15));
    check("wrr_busy", 512'(busy), 512'(0));

    // s1 locked on a 4-beat packet under backpressure while s0 waits
    do_reset();
    ord.push_back(1);
    ord.push_back(0);
    bp_mode = 1'b1;
    fork
      drive(1, 30, 1, 4, 48'h0000_0000_5600);
      begin
        @(posedge aclk);
        #1;
        drive(0, 40, 1, 2, 48'h0000_0000_7800);
      end
    join
    wait_drain();
    bp_mode = 1'b0;
    check("bp_s0_rdy", 512'(s0_rdy_bad), 512'(0));
    check("bp_cnt1", 512'(pkt_cnt1), 512'(1));
    check("bp_cnt0", 512'(pkt_cnt0), 512'(1));

    // Counter wrap at 4 bits: 17 single-beat packets
    do_reset();
    for (int i = 0; i < 17; i++) ord.push_back(0);
    drive(0, 50, 17, 1, 48'h0000_0000_9A00);
    wait_drain();
    check("wrap_cnt0", 512'(pkt_cnt0), 512'(1));

    // Source tag on tuser[47]
    do_reset();
    ord.push_back(1);
    drive(1, 60, 1, 1, 48'h0000_0000_0001);
    wait_drain();
    check("tag_user", 512'(last_user), 512'(TAG_EXP));

    // Reset mid-packet
    do_reset();
    mon_off = 1'b1;
    s0_axis_tvalid = 1'b1; s0_axis_tlast = 1'b0; s0_axis_tdata = 512'h1234; s0_axis_tuser = '0;
    repeat (2) @(posedge aclk);
    #1;
    check("mid_mvld", 512'(m_axis_tvalid), 512'(1));
    check("mid_busy", 512'(busy), 512'(1));
    #2;
    areset = 1'b1;
    #1;
    check("arst_mvld", 512'(m_axis_tvalid), 512'(0));
    check("arst_busy", 512'(busy), 512'(0));
    check("arst_s0rdy", 512'(s0_axis_tready), 512'(0));
    s0_axis_tvalid = 1'b0;
    @(posedge aclk);
    #1;
    do_reset();
    check("post_busy", 512'(busy), 512'(0));
    check("post_cnt0", 512'(pkt_cnt0), 512'(0));
    ord.push_back(1);
    drive(1, 70, 1, 1, 48'h0000_0000_BC00);
    wait_drain();
    check("post_cnt1", 512'(pkt_cnt1), 512'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule
